// File: rtl/dmem_pkg.sv
// Shared defaults, FSM encoding and lane helper for the data memory controller.
package dmem_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_MEM_AW = 13;
  localparam int LANES      = DEF_DATA_W / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_bank_array.sv
// Single-port synchronous RAM with per-byte write enables and read-first ordering.
module dmem_bank_array #(
  parameter int DATA_W = 24,
  parameter int AW     = 13,
  parameter int LANES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read and write at the same edge yields the pre-write word.
  always_ff @(posedge clk) begin
    if (rd_en_i)
      rdata_q <= mem_q[addr_i];
    if (wr_en_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i])
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: post-reset zero-fill sweep, region decode, byte-lane
// writes and a latency-1 registered read with valid/error strobes.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MEM_AW     = DEF_MEM_AW,
  parameter int REGION_SEL = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic                read_enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_enable,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_valid,
  output logic                addr_error,
  output logic                busy
);

  localparam int              LN       = lanes_of(DATA_W);
  localparam int              RW       = ADDR_W - MEM_AW;
  localparam logic [RW-1:0]   REGION_V = RW'(REGION_SEL);
  localparam logic [MEM_AW-1:0] LAST   = '1;

  state_e              state_q;
  logic [MEM_AW-1:0]   cnt_q, cnt_d;
  logic                busy_q, rvalid_q, aerr_q, have_data_q;
  logic                in_region, serve, rd_acc, wr_acc;

  logic                bank_wr;
  logic [LN-1:0]       bank_be;
  logic [MEM_AW-1:0]   bank_addr;
  logic [DATA_W-1:0]   bank_wdata, bank_rdata;

  assign in_region = (address[ADDR_W-1:MEM_AW] == REGION_V);
  assign serve     = (state_q == ST_IDLE);
  assign rd_acc    = serve && in_region && read_enable;
  assign wr_acc    = serve && in_region && write_enable;
  assign cnt_d     = cnt_q + 1'b1;

  // The sweep owns the RAM port until the FSM reaches IDLE.
  always_comb begin
    bank_wr    = 1'b1;
    bank_be    = '1;
    bank_addr  = cnt_q;
    bank_wdata = '0;
    if (serve) begin
      bank_wr    = wr_acc;
      bank_be    = byte_enable;
      bank_addr  = address[MEM_AW-1:0];
      bank_wdata = write_data;
    end
  end

  dmem_bank_array #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW),
    .LANES  (LN)
  ) u_bank (
    .clk     (clk),
    .rd_en_i (rd_acc),
    .wr_en_i (bank_wr),
    .be_i    (bank_be),
    .addr_i  (bank_addr),
    .wdata_i (bank_wdata),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= (INIT_ZERO != 0);
      rvalid_q    <= 1'b0;
      aerr_q      <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          rvalid_q <= 1'b0;
          aerr_q   <= 1'b0;
          cnt_q    <= cnt_d;
          if (cnt_q == LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          rvalid_q <= rd_acc;
          aerr_q   <= (read_enable || write_enable) && !in_region;
          if (rd_acc)
            have_data_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The RAM output register has no reset, so mask it until a read has landed.
  assign read_data  = have_data_q ? bank_rdata : '0;
  assign read_valid = rvalid_q;
  assign addr_error = aerr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a 16-word instance for sweep/reset behaviour and a
// full-size instance for lanes, collisions, region decode and throughput.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [13:0] addr = '0;
  logic [23:0] wd   = '0;
  logic [2:0]  be   = '0;

  logic [23:0] rd_a, rd_b;
  logic        rv_a, ae_a, busy_a;
  logic        rv_b, ae_b, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(24), .ADDR_W(14), .MEM_AW(4), .REGION_SEL(0), .INIT_ZERO(1)) dut_a (
    .clk(clk), .reset(rst), .write_enable(we), .read_enable(re), .address(addr),
    .write_data(wd), .byte_enable(be), .read_data(rd_a), .read_valid(rv_a),
    .addr_error(ae_a), .busy(busy_a)
  );

  data_memory_ctrl dut_b (
    .clk(clk), .reset(rst), .write_enable(we), .read_enable(re), .address(addr),
    .write_data(wd), .byte_enable(be), .read_data(rd_b), .read_valid(rv_b),
    .addr_error(ae_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [23:0] d, input logic [2:0] b);
    we = 1'b1; re = 1'b0; addr = a; wd = d; be = b;
    tick();
    we = 1'b0; be = '0;
  endtask

  task automatic rd(input logic [13:0] a);
    re = 1'b1; we = 1'b0; addr = a;
    tick();
    re = 1'b0;
  endtask

  initial begin
    int strobes;
    int nonzero;

    tick(); tick();
    chk("rst_busy", {31'd0, busy_a}, 32'd1);
    chk("rst_rdata", {8'd0, rd_a}, 32'd0);
    chk("rst_rvalid", {31'd0, rv_a}, 32'd0);
    chk("rst_aerr", {31'd0, ae_a}, 32'd0);

    // Sweep with a read of address 3 pending the whole time.
    rst = 1'b0;
    re = 1'b1; addr = 14'd3;
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rv_a || ae_a) strobes++;
    end
    chk("sweep_busy15", {31'd0, busy_a}, 32'd1);
    chk("sweep_drop", strobes, 0);
    re = 1'b0;
    tick();
    chk("sweep_busy16", {31'd0, busy_a}, 32'd0);
    chk("sweep_drop_last", {30'd0, rv_a, ae_a}, 32'd0);

    nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      rd(14'(i));
      if (rd_a !== 24'd0 || rv_a !== 1'b1) nonzero++;
    end
    chk("sweep_zero", nonzero, 0);

    // Dirty every word, then reset mid-sweep and expect a full restart.
    for (int i = 0; i < 16; i++) wr(14'(i), 24'hA5A5A5, 3'b111);
    rd(14'd9);
    chk("dirty_word", {8'd0, rd_a}, 32'h00A5A5A5);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy_a}, 32'd1);
    chk("midrst_rdata", {8'd0, rd_a}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("restart_busy15", {31'd0, busy_a}, 32'd1);
    tick();
    chk("restart_busy16", {31'd0, busy_a}, 32'd0);
    nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      rd(14'(i));
      if (rd_a !== 24'd0) nonzero++;
    end
    chk("restart_zero", nonzero, 0);

    // Full-size instance needs its 8192-cycle sweep.
    for (int i = 0; i < 9000 && busy_b; i++) tick();
    chk("b_ready", {31'd0, busy_b}, 32'd0);

    // Byte lanes.
    wr(14'd2, 24'hABCDEF, 3'b111);
    wr(14'd2, 24'h112233, 3'b010);
    wr(14'd2, 24'h000000, 3'b000);
    chk("be_zero_noerr", {31'd0, ae_b}, 32'd0);
    rd(14'd2);
    chk("lane_data", {8'd0, rd_b}, 32'h00AB22EF);
    chk("lane_valid", {31'd0, rv_b}, 32'd1);
    tick();
    chk("valid_pulse", {31'd0, rv_b}, 32'd0);
    chk("rdata_hold", {8'd0, rd_b}, 32'h00AB22EF);

    // Read-first collision.
    wr(14'd5, 24'h000123, 3'b111);
    we = 1'b1; re = 1'b1; addr = 14'd5; wd = 24'h000456; be = 3'b111;
    tick();
    we = 1'b0; re = 1'b0; be = '0;
    chk("coll_old", {8'd0, rd_b}, 32'h00000123);
    chk("coll_valid", {31'd0, rv_b}, 32'd1);
    rd(14'd5);
    chk("coll_new", {8'd0, rd_b}, 32'h00000456);

    // Region decode.
    wr(14'h2005, 24'h777777, 3'b111);
    chk("oor_wr_err", {31'd0, ae_b}, 32'd1);
    tick();
    chk("oor_err_pulse", {31'd0, ae_b}, 32'd0);
    rd(14'h0005);
    chk("oor_unchanged", {8'd0, rd_b}, 32'h00000456);
    rd(14'h2005);
    chk("oor_rd_err", {31'd0, ae_b}, 32'd1);
    chk("oor_rd_novalid", {31'd0, rv_b}, 32'd0);
    chk("oor_rd_hold", {8'd0, rd_b}, 32'h00000456);

    // Throughput: four back-to-back reads.
    for (int i = 0; i < 4; i++) wr(14'(16 + i), 24'(20 + i), 3'b111);
    re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 14'(16 + i);
      tick();
      chk("b2b_valid", {31'd0, rv_b}, 32'd1);
      chk("b2b_data", {8'd0, rd_b}, 32'(20 + i));
    end
    re = 1'b0;
    tick();
    chk("b2b_end", {31'd0, rv_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
